// File: rtl/y86_pkg.sv
// Shared Y86-64 execute-stage definitions: ALU/condition function codes,
// CC bit positions, the CC reset value and the condition-code unit state type.
package y86_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  localparam int ZF = 2;
  localparam int SF = 1;
  localparam int OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } cc_state_e;

  function automatic logic alu_fun_legal(input logic [3:0] fun);
    return fun <= ALU_XOR;
  endfunction

endpackage

// File: rtl/cc_unit_cond_eval.sv
// Combinational jXX/cmovXX condition evaluator over a {ZF,SF,OF} code.
// Also used by the writeback-stage cmov check.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] cond_fun,
  output logic       cnd,
  output logic       illegal
);

  logic lt;

  assign lt = cc[SF] ^ cc[OF];

  always_comb begin
    cnd     = 1'b0;
    illegal = 1'b0;
    case (cond_fun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | cc[ZF];
      C_L:      cnd = lt;
      C_E:      cnd = cc[ZF];
      C_NE:     cnd = ~cc[ZF];
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~cc[ZF];
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cc_unit.sv
// Y86-64 condition-code unit: derives ZF/SF/OF from the ALU result, holds the
// architectural CC register and produces a registered branch/cmov condition.
module cc_unit
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             set_cc,
  input  logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] val_e,
  input  logic [3:0]       cond_fun,
  input  logic             stall,
  input  logic             bubble,
  input  logic             exc_in,
  output logic [2:0]       cc,
  output logic             cnd,
  output logic             cnd_valid,
  output logic             fun_err,
  output logic             frozen
);

  cc_state_e  state_q, state_d;
  logic [2:0] flags_new;
  logic       a_msb, b_msb, e_msb;
  logic       alu_ok;
  logic       cc_write;
  logic       cnd_raw, cond_illegal;
  logic       unused_operand_bits;

  assign a_msb  = alu_a[WIDTH-1];
  assign b_msb  = alu_b[WIDTH-1];
  assign e_msb  = val_e[WIDTH-1];
  assign alu_ok = alu_fun_legal(alu_fun);

  // Only the sign bits of the operands matter for overflow.
  assign unused_operand_bits = ^{alu_a[WIDTH-2:0], alu_b[WIDTH-2:0]};

  always_comb begin
    flags_new     = 3'b000;
    flags_new[ZF] = (val_e == '0);
    flags_new[SF] = e_msb;
    case (alu_fun)
      ALU_ADD: flags_new[OF] = (a_msb == b_msb) && (e_msb != a_msb);
      ALU_SUB: flags_new[OF] = (a_msb != b_msb) && (e_msb != b_msb);
      default: flags_new[OF] = 1'b0;
    endcase
  end

  // The condition always sees the CC as it stood before this instruction.
  cond_eval u_cond_eval (
    .cc       (cc),
    .cond_fun (cond_fun),
    .cnd      (cnd_raw),
    .illegal  (cond_illegal)
  );

  assign cc_write = (state_q == RUN) && valid_in && set_cc && !stall &&
                    !bubble && !exc_in && alu_ok;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (exc_in) state_d = FROZEN;
      FROZEN:  state_d = FROZEN;
      default: state_d = RUN;
    endcase
  end

  assign frozen = (state_q == FROZEN);

  // An exception freezes the unit even under stall, so the freezing edge
  // also invalidates the E/M condition in the same way FROZEN does.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc        <= CC_RESET;
      cnd       <= 1'b0;
      cnd_valid <= 1'b0;
      fun_err   <= 1'b0;
    end else if (frozen || exc_in) begin
      cnd_valid <= 1'b0;
      fun_err   <= 1'b0;
    end else if (!stall) begin
      if (bubble) begin
        cnd       <= 1'b0;
        cnd_valid <= 1'b0;
        fun_err   <= 1'b0;
      end else begin
        cnd       <= valid_in & cnd_raw;
        cnd_valid <= valid_in;
        fun_err   <= valid_in & (cond_illegal | (set_cc & ~alu_ok));
        if (cc_write) cc <= flags_new;
      end
    end
  end

endmodule
